// File: rtl/booth_pkg.sv
// booth_pkg: shared state encoding, Booth op codes and default width for the Booth multiplier
package booth_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_DONE = 2'd2} state_t;
    typedef enum logic [1:0] {OP_NOP = 2'd0, OP_ADD = 2'd1, OP_SUB = 2'd2} op_t;
endpackage

// File: rtl/booth_addsub.sv
// booth_addsub: ripple-carry add/sub (s = a + (b ^ m) + ci), one guard bit wider than the operands
module booth_addsub #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    input  logic         m,
    output logic [N-1:0] s
);
    logic [N-1:0] c;
    logic [N-1:0] bx;
    assign bx   = b ^ {N{m}};
    assign c[0] = ci;
    for (genvar k = 0; k < N; k++) begin : g_fa
        assign s[k] = a[k] ^ bx[k] ^ c[k];
        if (k < N - 1) begin : g_c
            assign c[k+1] = (a[k] & bx[k]) | (c[k] & (a[k] ^ bx[k]));
        end
    end
endmodule

// File: rtl/booth_mul_ctrl.sv
// booth_mul_ctrl: sequential radix-2 Booth controller for signed WIDTH x WIDTH multiplication
module booth_mul_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    state_t           state, nxt;
    op_t              op;
    logic [WIDTH:0]   acc, mcand, sum, acc_nx;
    logic [WIDTH-1:0] mplier, mplier_nx;
    logic             q1;
    logic [CNT_W-1:0] cnt;
    logic             last;

    booth_addsub #(.N(WIDTH + 1)) u_addsub (
        .a (acc),
        .b (op == OP_NOP ? '0 : mcand),
        .ci(op == OP_SUB),
        .m (op == OP_SUB),
        .s (sum)
    );

    // Booth recoding of {Q[0], Q_1}, the shifted next values and the next FSM state
    always_comb begin
        op        = (mplier[0] & ~q1) ? OP_SUB : (~mplier[0] & q1) ? OP_ADD : OP_NOP;
        acc_nx    = {sum[WIDTH], sum[WIDTH:1]};
        mplier_nx = {sum[0], mplier[WIDTH-1:1]};
        last      = cnt == CNT_W'(1);
        nxt       = state;
        case (state)
            ST_IDLE: nxt = start ? ST_CALC : ST_IDLE;
            ST_CALC: nxt = last ? ST_DONE : ST_CALC;
            default: nxt = ST_IDLE;
        endcase
    end

    // State register plus registered busy/done derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nxt;
            busy  <= nxt != ST_IDLE;
            done  <= nxt == ST_DONE;
        end
    end

    // Operand capture on an accepted start, one add/shift iteration per CALC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            q1      <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else if (state == ST_IDLE && start) begin
            acc    <= '0;
            mcand  <= {a[WIDTH-1], a};
            mplier <= b;
            q1     <= 1'b0;
            cnt    <= CNT_W'(WIDTH);
        end else if (state == ST_CALC) begin
            acc    <= acc_nx;
            mplier <= mplier_nx;
            q1     <= mplier[0];
            cnt    <= cnt - CNT_W'(1);
            if (last) product <= {acc_nx[WIDTH-1:0], mplier_nx};
        end
    end
endmodule

// File: tb/tb_booth_mul_ctrl.sv
// tb_booth_mul_ctrl: table-driven and sequence checks of booth_mul_ctrl against a product scoreboard
module tb_booth_mul_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy, done;
    logic [2*W-1:0] product;

    int total_n = 0;
    int pass_n  = 0;
    int done_n  = 0;
    logic [2*W-1:0] exp_q[$];
    vec_t vt[7];

    booth_mul_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
        total_n++;
        if (got === want) pass_n++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expected product
    always @(negedge clk) begin
        if (done) begin
            done_n++;
            if (exp_q.size() == 0) begin
                total_n++;
                $display("FAIL spurious_done: done=1 product=%0h with no operation outstanding", product);
            end else check("product", product, exp_q.pop_front());
        end
    end

    // Launch one operation and check latency, busy length and single-cycle done
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2*W-1:0] pe, input string nm);
        int lat, bcnt;
        lat = 0;
        bcnt = 0;
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        exp_q.push_back(pe);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        check({nm, "_latency"}, lat, 9);
        check({nm, "_busy_cycles"}, bcnt, 9);
        @(negedge clk);
        check({nm, "_idle_after_done"}, {30'd0, busy, done}, 0);
    endtask

    initial begin
        int lat, d0, t1, t2;
        vt[0] = '{8'd3,   8'd5,   16'h000F};
        vt[1] = '{8'hFD,  8'd5,   16'hFFF1};
        vt[2] = '{8'd127, 8'h80,  16'hC080};
        vt[3] = '{8'h80,  8'h80,  16'h4000};
        vt[4] = '{8'd0,   8'hFF,  16'h0000};
        vt[5] = '{8'hFF,  8'hFF,  16'h0001};
        vt[6] = '{8'd127, 8'd127, 16'h3F01};

        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_product", {16'd0, product}, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_op(vt[i].a, vt[i].b, vt[i].p, $sformatf("vec%0d", i));

        // start while busy is ignored
        d0 = done_n;
        lat = 0;
        @(negedge clk);
        a = 8'd3; b = 8'd5; start = 1'b1;
        exp_q.push_back(16'h000F);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 4) begin
                a = 8'd7; b = 8'd7; start = 1'b1;
            end
            if (k == 5) start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("busy_start_latency", lat, 9);
        repeat (12) @(negedge clk);
        check("busy_start_one_done", done_n - d0, 1);
        run_op(8'd7, 8'd7, 16'h0031, "after_busy");

        // reset mid-operation aborts immediately without a done pulse
        @(negedge clk);
        a = 8'd100; b = 8'd100; start = 1'b1;
        exp_q.push_back(16'h2710);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_done", {31'd0, done}, 0);
        check("midrst_product", {16'd0, product}, 0);
        exp_q.delete();
        d0 = done_n;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst_no_done", done_n - d0, 0);
        run_op(8'd2, 8'hFC, 16'hFFF8, "after_rst");

        // back-to-back with start held high
        d0 = done_n;
        t1 = 0;
        t2 = 0;
        @(negedge clk);
        a = 8'd6; b = 8'd7; start = 1'b1;
        exp_q.push_back(16'h002A);
        exp_q.push_back(16'hFFD6);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) a = 8'hFA;
            if (done) begin
                if (t1 == 0) t1 = k;
                else begin
                    t2 = k;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("b2b_first_latency", t1, 9);
        check("b2b_spacing", t2 - t1, 10);
        repeat (15) @(negedge clk);
        check("b2b_done_count", done_n - d0, 2);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
